simon_data_input: RTL and testbench
===================================

SIMON_DATA_INPUT -- requirements
Module: simon_data_input

Interface
REQ-001 Parameter N, default 16: SIMON word width in bits (package constant).
REQ-002 Parameter M, default 4: number of key words; M*N SHALL equal 4*N, so M=4.
REQ-003 clk  in  1  single system clock; all state changes on the rising edge.
REQ-004 nR  in  1  reset, asynchronous and active-low.
REQ-005 in_newPKT  in  1  upstream has a valid packet on `in`.
REQ-006 in  in  (N/2+2) bytes  packet: the top byte is info, the next byte is count, and the low N/2 bytes (4N bits) are the payload.
REQ-007 loadDATA  in  1  consumer has taken inDATA.
REQ-008 loadKEY  in  1  consumer has taken KEY.
REQ-009 in_loadPKT  out  1  packet captured (acknowledge to upstream).
REQ-010 in_donePKT  out  1  packet fully consumed; ready for the next packet.
REQ-011 newKEY  out  1  KEY holds a new key.
REQ-012 newDATA  out  1  inDATA holds a new block.
REQ-013 infoIN  out  8  latched info byte.
REQ-014 countIN  out  8  latched count byte.
REQ-015 inDATA  out  2 x N  current data block.
REQ-016 KEY  out  M x N  latched key.

Function
REQ-017 States SHALL be IDLE, ACK, DECODE, KEY_HI, KEY_LO, DATA_HI, DATA_LO and DONE.
REQ-018 IDLE: when in_newPKT=1, latch the whole `in` into an internal register, set infoIN and countIN, and go to ACK.
REQ-019 ACK: in_loadPKT=1; when in_newPKT=0, go to DECODE.
REQ-020 DECODE: if infoIN equals IN_IKEY (8'h01), load KEY from the payload and go to KEY_HI; any other value is a data packet, so clear the block index and go to DATA_HI.
REQ-021 KEY word mapping: KEY[M-1] is the most significant payload word and KEY[0] the least significant.
REQ-022 KEY_HI: newKEY=1; when loadKEY=1, go to KEY_LO.
REQ-023 KEY_LO: newKEY=0; when loadKEY=0, go to DONE.
REQ-024 Data payload holds two 2N-bit blocks; the upper block (payload[4N-1:2N]) SHALL be sent first, then the lower block.
REQ-025 DATA_HI: inDATA=current block and newDATA=1; when loadDATA=1, go to DATA_LO.
REQ-026 DATA_LO: newDATA=0; when loadDATA=0, go to DATA_HI with the block index incremented if it was block 0, else go to DONE.
REQ-027 DONE: in_donePKT=1, held until in_newPKT=1; that edge behaves as in IDLE, capturing the packet, dropping in_donePKT and entering ACK.
REQ-028 Outputs SHALL be registered: each handshake output changes one clock after the state change that causes it.
REQ-029 KEY, inDATA, infoIN and countIN SHALL hold their values between updates.
REQ-030 A change on `in` outside the IDLE/DONE capture edge SHALL be ignored.
REQ-031 Handshake inputs that are already high on entering a waiting state SHALL be acted on at the next edge (level-sensitive, no edge detection).

Reset
REQ-032 While nR=0, state is IDLE and every output is 0, including KEY, inDATA, infoIN, countIN and the block index.
REQ-033 Reset mid-packet SHALL abort the packet; after release the block waits in IDLE for in_newPKT.

Structure
REQ-034 The shared package (SIMON definitions) SHALL hold N, M, the info codes IN_IKEY=8'h01 and IN_IENC=8'h02, the packet width (N/2+2 bytes) and the state enum.
REQ-035 Implementation SHALL be a single module with no sub-module; payload slicing is combinational from the latched packet register.

Verification
REQ-036 Reset: nR=0 -> all outputs 0 and state IDLE; release -> outputs unchanged until in_newPKT=1.
REQ-037 Key packet: in={01,00,key 64'h1918_1110_0908_0100}, in_newPKT=1 -> in_loadPKT=1, countIN=00 and infoIN=01. After in_newPKT=0: KEY[3]=1918, KEY[0]=0100 and newKEY=1. After the loadKEY rise and fall: newKEY=0, then in_donePKT=1.
REQ-038 Data packet: in={02,01,6565_6877,9A9A_9788}.
- Result: inDATA=6565_6877 with newDATA=1.
- After the loadDATA handshake, inDATA=9A9A_9788 with newDATA=1.
- After the second handshake, in_donePKT=1 and countIN=01.
REQ-039 Back-to-back packets: in_newPKT raised 3 cycles after in_donePKT -> in_donePKT falls, the new packet is captured, and KEY is unchanged by the data packet.
REQ-040 Held handshake: loadDATA held high into the second DATA_HI -> second block acknowledged immediately, and newDATA pulses for one cycle.
REQ-041 Reset asserted while in DATA_LO -> outputs zeroed, and in_donePKT is never asserted for the aborted packet.

Source files
------------

// File: rtl/simon_data_input_pkg.sv
// ============================================================================
// simon_data_input_pkg : shared SIMON packet definitions and input-FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package simon_data_input_pkg;

  localparam int N         = 16;
  localparam int M         = 4;
  localparam int PKT_BYTES = N / 2 + 2;
  localparam int PKT_W     = PKT_BYTES * 8;
  localparam int PAYLOAD_W = 4 * N;

  localparam logic [7:0] IN_IKEY = 8'h01;
  localparam logic [7:0] IN_IENC = 8'h02;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACK     = 3'd1,
    DECODE  = 3'd2,
    KEY_HI  = 3'd3,
    KEY_LO  = 3'd4,
    DATA_HI = 3'd5,
    DATA_LO = 3'd6,
    DONE    = 3'd7
  } state_t;

endpackage

`default_nettype wire

// File: rtl/simon_data_input.sv
// ============================================================================
// simon_data_input : captures a SIMON packet and hands out a key or two blocks
// Rev 1.0
// ============================================================================
`default_nettype none

module simon_data_input
  import simon_data_input_pkg::*;
(
  input  logic                   clk,
  input  logic                   nR,
  input  logic                   in_newPKT,
  input  logic [PKT_W-1:0]       in,
  input  logic                   loadDATA,
  input  logic                   loadKEY,
  output logic                   in_loadPKT,
  output logic                   in_donePKT,
  output logic                   newKEY,
  output logic                   newDATA,
  output logic [7:0]             infoIN,
  output logic [7:0]             countIN,
  output logic [1:0][N-1:0]      inDATA,
  output logic [M-1:0][N-1:0]    KEY
);

  state_t               r_state;
  logic [PAYLOAD_W-1:0] r_payload;
  logic                 r_blk;

  logic [2*N-1:0]       w_blk;
  logic [M*N-1:0]       w_key;

  // Upper half of the payload is the first block handed out.
  assign w_blk = r_blk ? r_payload[2*N-1:0] : r_payload[4*N-1:2*N];
  assign w_key = r_payload;

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      r_state    <= IDLE;
      r_payload  <= '0;
      r_blk      <= 1'b0;
      in_loadPKT <= 1'b0;
      in_donePKT <= 1'b0;
      newKEY     <= 1'b0;
      newDATA    <= 1'b0;
      infoIN     <= 8'h00;
      countIN    <= 8'h00;
      inDATA     <= '0;
      KEY        <= '0;
    end else begin
      in_loadPKT <= (r_state == ACK);
      newKEY     <= (r_state == KEY_HI);
      newDATA    <= (r_state == DATA_HI);
      // Done drops on the same edge that captures the next packet.
      in_donePKT <= (r_state == DONE) && !in_newPKT;

      case (r_state)
        IDLE, DONE: begin
          if (in_newPKT) begin
            r_payload <= in[PAYLOAD_W-1:0];
            infoIN    <= in[PKT_W-1 -: 8];
            countIN   <= in[PKT_W-9 -: 8];
            r_state   <= ACK;
          end
        end
        ACK: begin
          if (!in_newPKT) r_state <= DECODE;
        end
        DECODE: begin
          if (infoIN == IN_IKEY) begin
            KEY     <= w_key;
            r_state <= KEY_HI;
          end else begin
            r_blk   <= 1'b0;
            r_state <= DATA_HI;
          end
        end
        KEY_HI: begin
          if (loadKEY) r_state <= KEY_LO;
        end
        KEY_LO: begin
          if (!loadKEY) r_state <= DONE;
        end
        DATA_HI: begin
          inDATA <= w_blk;
          if (loadDATA) r_state <= DATA_LO;
        end
        DATA_LO: begin
          if (!loadDATA) begin
            if (!r_blk) begin
              r_blk   <= 1'b1;
              r_state <= DATA_HI;
            end else begin
              r_state <= DONE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_simon_data_input.sv
// ============================================================================
// tb_simon_data_input : scoreboard bench for simon_data_input
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_simon_data_input;
  import simon_data_input_pkg::*;

  localparam int K_PKT  = 0;
  localparam int K_KEY  = 1;
  localparam int K_DATA = 2;
  localparam int K_DONE = 3;

  localparam int S_LOAD = 0;
  localparam int S_DONE = 1;
  localparam int S_NKEY = 2;
  localparam int S_NDAT = 3;

  typedef struct {
    int          kind;
    logic [63:0] val;
  } exp_t;

  logic                clk;
  logic                nR;
  logic                in_newPKT;
  logic [PKT_W-1:0]    in;
  logic                loadDATA;
  logic                loadKEY;
  logic                in_loadPKT;
  logic                in_donePKT;
  logic                newKEY;
  logic                newDATA;
  logic [7:0]          infoIN;
  logic [7:0]          countIN;
  logic [1:0][N-1:0]   inDATA;
  logic [M-1:0][N-1:0] KEY;

  exp_t q[$];
  int   checks;
  int   errors;
  logic p_load, p_done, p_nkey, p_ndat;

  simon_data_input dut (
    .clk        (clk),
    .nR         (nR),
    .in_newPKT  (in_newPKT),
    .in         (in),
    .loadDATA   (loadDATA),
    .loadKEY    (loadKEY),
    .in_loadPKT (in_loadPKT),
    .in_donePKT (in_donePKT),
    .newKEY     (newKEY),
    .newDATA    (newDATA),
    .infoIN     (infoIN),
    .countIN    (countIN),
    .inDATA     (inDATA),
    .KEY        (KEY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [63:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic sb_check(input int kind, input logic [63:0] act);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected kind=%0d actual=%h required=none", kind, act);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || act !== e.val) begin
        errors++;
        $display("FAIL sb_kind%0d actual=%0d/%h required=%0d/%h", kind, kind, act, e.kind, e.val);
      end
    end
  endtask

  // Monitor: each rising handshake output presents one observable response.
  initial begin
    p_load = 1'b0; p_done = 1'b0; p_nkey = 1'b0; p_ndat = 1'b0;
  end
  always @(negedge clk) begin
    if (in_loadPKT && !p_load) sb_check(K_PKT,  {48'h0, infoIN, countIN});
    if (newKEY && !p_nkey)     sb_check(K_KEY,  KEY);
    if (newDATA && !p_ndat)    sb_check(K_DATA, {32'h0, inDATA});
    if (in_donePKT && !p_done) sb_check(K_DONE, {48'h0, infoIN, countIN});
    p_load = in_loadPKT;
    p_done = in_donePKT;
    p_nkey = newKEY;
    p_ndat = newDATA;
  end

  function automatic logic pick(input int sel);
    case (sel)
      S_LOAD:  return in_loadPKT;
      S_DONE:  return in_donePKT;
      S_NKEY:  return newKEY;
      default: return newDATA;
    endcase
  endfunction

  task automatic wait_out(input int sel, input logic lvl);
    int n;
    n = 0;
    while (pick(sel) !== lvl && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (pick(sel) !== lvl) begin
      errors++;
      $display("FAIL timeout sel=%0d actual=%b required=%b", sel, pick(sel), lvl);
    end
  endtask

  task automatic send_pkt(input logic [7:0] info, input logic [7:0] cnt, input logic [63:0] pay);
    in        = {info, cnt, pay};
    in_newPKT = 1'b1;
    wait_out(S_LOAD, 1'b1);
    in_newPKT = 1'b0;
    in        = {PKT_W{1'b1}};
  endtask

  task automatic take_data();
    wait_out(S_NDAT, 1'b1);
    loadDATA = 1'b1;
    wait_out(S_NDAT, 1'b0);
    loadDATA = 1'b0;
  endtask

  int ndat_hi;

  initial begin
    checks = 0; errors = 0;
    nR = 1'b0; in_newPKT = 1'b0; in = '0; loadDATA = 1'b0; loadKEY = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {12'h0, in_loadPKT, in_donePKT, newKEY, newDATA, infoIN, countIN, inDATA, KEY}, 128'h0);
    nR = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_release_idle", {12'h0, in_loadPKT, in_donePKT, newKEY, newDATA, infoIN, countIN, inDATA, KEY}, 128'h0);

    // Key packet
    push(K_PKT,  64'h0100);
    push(K_KEY,  64'h1918_1110_0908_0100);
    push(K_DONE, 64'h0100);
    send_pkt(8'h01, 8'h00, 64'h1918_1110_0908_0100);
    wait_out(S_NKEY, 1'b1);
    chk("key3", {112'h0, KEY[3]}, 128'h1918);
    chk("key0", {112'h0, KEY[0]}, 128'h0100);
    loadKEY = 1'b1;
    wait_out(S_NKEY, 1'b0);
    loadKEY = 1'b0;
    wait_out(S_DONE, 1'b1);

    // Data packet issued 3 cycles after done; `in` scrambled after capture
    repeat (3) @(posedge clk);
    #1;
    chk("done_held", {127'h0, in_donePKT}, 128'h1);
    push(K_PKT,  64'h0201);
    push(K_DATA, 64'h6565_6877);
    push(K_DATA, 64'h9A9A_9788);
    push(K_DONE, 64'h0201);
    send_pkt(8'h02, 8'h01, 64'h6565_6877_9A9A_9788);
    chk("done_dropped", {127'h0, in_donePKT}, 128'h0);
    take_data();
    take_data();
    wait_out(S_DONE, 1'b1);
    chk("count_after_data", {120'h0, countIN}, 128'h01);
    chk("key_kept", {64'h0, KEY}, {64'h0, 64'h1918_1110_0908_0100});

    // Held loadDATA into the second block
    push(K_PKT,  64'h0205);
    push(K_DATA, 64'h1111_2222);
    push(K_DATA, 64'h3333_4444);
    push(K_DONE, 64'h0205);
    send_pkt(8'h02, 8'h05, 64'h1111_2222_3333_4444);
    wait_out(S_NDAT, 1'b1);
    loadDATA = 1'b1;
    wait_out(S_NDAT, 1'b0);
    loadDATA = 1'b0;
    @(posedge clk); #1;
    loadDATA = 1'b1;
    ndat_hi = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (newDATA) ndat_hi++;
    end
    chk("held_pulse_width", 128'(ndat_hi), 128'd1);
    loadDATA = 1'b0;
    wait_out(S_DONE, 1'b1);

    // Reset while in DATA_LO aborts the packet
    push(K_PKT,  64'h0207);
    push(K_DATA, 64'hAAAA_BBBB);
    send_pkt(8'h02, 8'h07, 64'hAAAA_BBBB_CCCC_DDDD);
    wait_out(S_NDAT, 1'b1);
    loadDATA = 1'b1;
    wait_out(S_NDAT, 1'b0);
    nR = 1'b0;
    #1;
    chk("abort_outputs", {12'h0, in_loadPKT, in_donePKT, newKEY, newDATA, infoIN, countIN, inDATA, KEY}, 128'h0);
    loadDATA = 1'b0;
    @(posedge clk); #1;
    nR = 1'b1;
    ndat_hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (in_donePKT || newDATA) ndat_hi++;
    end
    chk("abort_no_done", 128'(ndat_hi), 128'd0);

    @(posedge clk); #1;
    chk("scoreboard_drained", 128'(q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
